// File: rtl/pwm_capture_pkg.sv
// Shared constants and types for the PWM capture block.
package pwm_capture_pkg;

  // Default measurement counter / data register width
  localparam int unsigned DefCntW = 16;

  // Register word addresses
  localparam int unsigned RegCtrl   = 0;
  localparam int unsigned RegStatus = 1;
  localparam int unsigned RegHigh   = 2;
  localparam int unsigned RegPeriod = 3;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlIrqEnBit = 1;
  localparam int unsigned CtrlClrBit   = 2;

  // STATUS bit positions
  localparam int unsigned StatusValidBit = 0;
  localparam int unsigned StatusOvfBit   = 1;

  // Capture FSM states
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArm      = 2'd1,
    StMeasHigh = 2'd2,
    StMeasLow  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_sync.sv
// Multi-flop synchroniser for the asynchronous PWM input, followed by one
// extra flop so that rising and falling edges appear as single-cycle pulses.
module pwm_capture_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic preset,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser and keep the previous level
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of a synchronised PWM input in
// pclk cycles and publishes each complete measurement to APB registers.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [CNT_W-1:0]  pwdata,
  output logic [CNT_W-1:0]  prdata,
  output logic              pready,
  input  logic              pwm_in,
  output logic              meas_irq
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic rise;
  logic fall;

  pwm_capture_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .pclk   (pclk),
    .preset (preset),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic sel_ctrl;
  logic sel_status;
  logic sel_high;
  logic sel_period;
  logic ctrl_wr;
  logic status_wr;
  logic clr_req;
  logic unused_pwdata;

  assign wr_en      = psel & penable & pwrite;
  assign sel_ctrl   = (paddr == ADDR_W'(RegCtrl));
  assign sel_status = (paddr == ADDR_W'(RegStatus));
  assign sel_high   = (paddr == ADDR_W'(RegHigh));
  assign sel_period = (paddr == ADDR_W'(RegPeriod));
  assign ctrl_wr    = wr_en & sel_ctrl;
  assign status_wr  = wr_en & sel_status;
  assign clr_req    = ctrl_wr & pwdata[CtrlClrBit];

  // Upper write-data bits have no register behind them
  assign unused_pwdata = ^pwdata[CNT_W-1:3];

  // ---------------------------------------------------------------------------
  // Control register
  // ---------------------------------------------------------------------------
  logic en_q;
  logic irq_en_q;

  // CTRL holds en and irq_en; clr is a write-only strobe and is not stored
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      en_q     <= pwdata[CtrlEnBit];
      irq_en_q <= pwdata[CtrlIrqEnBit];
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM and counters
  // ---------------------------------------------------------------------------
  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] hi_shadow_q, hi_shadow_d;
  logic             publish;
  logic             saturate;

  // Next-state, counter update and publish/saturate decisions
  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    hi_shadow_d = hi_shadow_q;
    publish     = 1'b0;
    saturate    = 1'b0;

    if (clr_req) begin
      // clr takes priority over everything, including a publish this cycle
      state_d     = pwdata[CtrlEnBit] ? StArm : StIdle;
      per_cnt_d   = '0;
      hi_cnt_d    = '0;
      hi_shadow_d = '0;
    end else if (!en_q) begin
      state_d   = StIdle;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StArm;
        end

        StArm: begin
          if (rise) begin
            state_d   = StMeasHigh;
            per_cnt_d = CntOne;
            hi_cnt_d  = CntOne;
          end
        end

        StMeasHigh: begin
          // A period that has already reached full scale cannot close in range
          if (per_cnt_q == CntMax) begin
            saturate  = 1'b1;
            state_d   = StArm;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
          end else begin
            per_cnt_d = per_cnt_q + CntOne;
            hi_cnt_d  = (hi_cnt_q == CntMax) ? hi_cnt_q : hi_cnt_q + CntOne;
            if (fall) begin
              state_d     = StMeasLow;
              hi_shadow_d = hi_cnt_q;
            end
          end
        end

        StMeasLow: begin
          if (rise) begin
            // per_cnt_q already equals the period, including a full-scale one
            publish   = 1'b1;
            state_d   = StMeasHigh;
            per_cnt_d = CntOne;
            hi_cnt_d  = CntOne;
          end else if (per_cnt_q == CntMax) begin
            saturate  = 1'b1;
            state_d   = StArm;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
          end else begin
            per_cnt_d = per_cnt_q + CntOne;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state, counters and high-time shadow
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= StIdle;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      hi_shadow_q <= '0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status and result registers
  // ---------------------------------------------------------------------------
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;

  // Sticky flags: W1C first, then hardware set wins, then clr wins over all
  always_comb begin
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    high_d   = high_q;
    period_d = period_q;

    if (status_wr) begin
      valid_d = valid_q & ~pwdata[StatusValidBit];
      ovf_d   = ovf_q & ~pwdata[StatusOvfBit];
    end
    if (publish) begin
      valid_d  = 1'b1;
      high_d   = hi_shadow_q;
      period_d = per_cnt_q;
    end
    if (saturate) begin
      ovf_d = 1'b1;
    end
    if (clr_req) begin
      valid_d  = 1'b0;
      ovf_d    = 1'b0;
      high_d   = '0;
      period_d = '0;
    end
  end

  // Status flags and published measurement
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      high_q   <= high_d;
      period_q <= period_d;
    end
  end

  // Interrupt pulse lands in the cycle after the publish edge
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      meas_irq <= 1'b0;
    end else begin
      meas_irq <= publish & irq_en_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // Combinational read mux, zero whenever no read is addressed
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      if (sel_ctrl) begin
        prdata[CtrlEnBit]    = en_q;
        prdata[CtrlIrqEnBit] = irq_en_q;
      end else if (sel_status) begin
        prdata[StatusValidBit] = valid_q;
        prdata[StatusOvfBit]   = ovf_q;
      end else if (sel_high) begin
        prdata = high_q;
      end else if (sel_period) begin
        prdata = period_q;
      end
    end
  end

  assign pready = 1'b1;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: drives PWM trains and APB accesses, compares register
// reads and interrupt counts with a waveform-level model of expected results.
module tb_pwm_capture;

  localparam logic [3:0] RCtrl   = 4'h0;
  localparam logic [3:0] RStatus = 4'h1;
  localparam logic [3:0] RHigh   = 4'h2;
  localparam logic [3:0] RPeriod = 4'h3;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pwm_in;
  logic        meas_irq;

  int n_checks = 0;
  int n_pass   = 0;
  int irq_seen = 0;

  // Reference model: what software should currently read back
  int m_high   = 0;
  int m_period = 0;
  bit m_valid  = 1'b0;
  bit m_ovf    = 1'b0;

  pwm_capture dut (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pwm_in   (pwm_in),
    .meas_irq (meas_irq)
  );

  always #5 pclk = ~pclk;

  // Count cycles with the interrupt high, sampled mid-cycle
  always @(negedge pclk) begin
    if (meas_irq === 1'b1) irq_seen++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_level(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) tick();
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [15:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [15:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  // n complete periods, then the closing rise and a short pulse, then low
  task automatic run_train(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      drive_level(1'b1, h);
      drive_level(1'b0, p - h);
    end
    drive_level(1'b1, h);
    drive_level(1'b0, 6);
  endtask

  function automatic logic [15:0] exp_status();
    return {14'b0, m_ovf, m_valid};
  endfunction

  task automatic test_reset();
    logic [15:0] rd;
    preset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pwm_in = i[0];
      tick();
    end
    for (int a = 0; a < 16; a++) begin
      apb_read(4'(a), rd);
      n_checks++;
      if (rd !== 16'h0) $display("FAIL reset_prdata[%0d]: got %h want 0000", a, rd);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (pready !== 1'b1) $display("FAIL reset_pready: got %b want 1", pready);
    else n_pass++;
    n_checks++;
    if (meas_irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", meas_irq);
    else n_pass++;
    pwm_in = 1'b0;
    preset = 1'b0;
    repeat (3) tick();
    for (int a = 0; a < 4; a++) begin
      apb_read(4'(a), rd);
      n_checks++;
      if (rd !== 16'h0) $display("FAIL post_reset_reg[%0d]: got %h want 0000", a, rd);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_measure();
    for (int i = 0; i < 5; i++) begin
      int h, l, n, irq0, exp_irq;
      bit ie;
      logic [15:0] rd;
      if (i == 0) begin
        h = 4; l = 6; n = 3; ie = 1'b1;
      end else begin
        h  = int'($urandom_range(1, 12));
        l  = int'($urandom_range(1, 12));
        n  = int'($urandom_range(1, 3));
        ie = (i != 2);
      end
      apb_write(RCtrl, {14'b0, ie, 1'b1});
      repeat (2) tick();
      apb_write(RStatus, 16'h1);
      m_valid = 1'b0;
      apb_read(RStatus, rd);
      n_checks++;
      if (rd !== exp_status()) $display("FAIL w1c_idle[%0d]: got %h want %h", i, rd, exp_status());
      else n_pass++;
      irq0 = irq_seen;
      run_train(h, h + l, n);
      m_high = h; m_period = h + l; m_valid = 1'b1;
      exp_irq = ie ? n : 0;
      apb_read(RHigh, rd);
      n_checks++;
      if (rd !== 16'(m_high)) $display("FAIL meas_high[%0d]: got %0d want %0d", i, rd, m_high);
      else n_pass++;
      apb_read(RPeriod, rd);
      n_checks++;
      if (rd !== 16'(m_period)) $display("FAIL meas_period[%0d]: got %0d want %0d", i, rd, m_period);
      else n_pass++;
      apb_read(RStatus, rd);
      n_checks++;
      if (rd !== exp_status()) $display("FAIL meas_status[%0d]: got %h want %h", i, rd, exp_status());
      else n_pass++;
      n_checks++;
      if (irq_seen - irq0 !== exp_irq)
        $display("FAIL meas_irq_count[%0d]: got %0d want %0d", i, irq_seen - irq0, exp_irq);
      else n_pass++;
      apb_write(RCtrl, 16'h0);
    end
  endtask

  task automatic test_w1c();
    logic [15:0] rd;
    int irq0;
    apb_write(RCtrl, 16'h3);
    repeat (2) tick();
    irq0 = irq_seen;
    drive_level(1'b1, 5);
    drive_level(1'b0, 4);
    // Closing rise; the W1C write commits on the edge that publishes it
    pwm_in = 1'b1;
    tick();
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = RStatus; pwdata = 16'h1;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    drive_level(1'b0, 6);
    m_high = 5; m_period = 9; m_valid = 1'b1;
    apb_read(RStatus, rd);
    n_checks++;
    if (rd !== exp_status()) $display("FAIL w1c_vs_set_status: got %h want %h", rd, exp_status());
    else n_pass++;
    apb_read(RHigh, rd);
    n_checks++;
    if (rd !== 16'(m_high)) $display("FAIL w1c_vs_set_high: got %0d want %0d", rd, m_high);
    else n_pass++;
    apb_read(RPeriod, rd);
    n_checks++;
    if (rd !== 16'(m_period)) $display("FAIL w1c_vs_set_period: got %0d want %0d", rd, m_period);
    else n_pass++;
    n_checks++;
    if (irq_seen - irq0 !== 1) $display("FAIL w1c_irq_count: got %0d want 1", irq_seen - irq0);
    else n_pass++;
    apb_write(RStatus, 16'h1);
    m_valid = 1'b0;
    apb_read(RStatus, rd);
    n_checks++;
    if (rd !== exp_status()) $display("FAIL w1c_idle_status: got %h want %h", rd, exp_status());
    else n_pass++;
    apb_write(RCtrl, 16'h0);
  endtask

  task automatic test_ovf();
    logic [15:0] rd;
    int irq0;
    apb_write(RCtrl, 16'h3);
    apb_write(RStatus, 16'h3);
    m_valid = 1'b0; m_ovf = 1'b0;
    tick();
    irq0 = irq_seen;
    drive_level(1'b1, 66000);
    drive_level(1'b0, 5);
    m_ovf = 1'b1;
    apb_read(RStatus, rd);
    n_checks++;
    if (rd !== exp_status()) $display("FAIL ovf_status: got %h want %h", rd, exp_status());
    else n_pass++;
    apb_read(RHigh, rd);
    n_checks++;
    if (rd !== 16'(m_high)) $display("FAIL ovf_high_kept: got %0d want %0d", rd, m_high);
    else n_pass++;
    apb_read(RPeriod, rd);
    n_checks++;
    if (rd !== 16'(m_period)) $display("FAIL ovf_period_kept: got %0d want %0d", rd, m_period);
    else n_pass++;
    n_checks++;
    if (irq_seen - irq0 !== 0) $display("FAIL ovf_no_irq: got %0d want 0", irq_seen - irq0);
    else n_pass++;
    run_train(3, 7, 2);
    m_high = 3; m_period = 7; m_valid = 1'b1;
    apb_read(RHigh, rd);
    n_checks++;
    if (rd !== 16'(m_high)) $display("FAIL resume_high: got %0d want %0d", rd, m_high);
    else n_pass++;
    apb_read(RPeriod, rd);
    n_checks++;
    if (rd !== 16'(m_period)) $display("FAIL resume_period: got %0d want %0d", rd, m_period);
    else n_pass++;
    apb_read(RStatus, rd);
    n_checks++;
    if (rd !== exp_status()) $display("FAIL resume_status: got %h want %h", rd, exp_status());
    else n_pass++;
    n_checks++;
    if (irq_seen - irq0 !== 2) $display("FAIL resume_irq_count: got %0d want 2", irq_seen - irq0);
    else n_pass++;
    apb_write(RCtrl, 16'h0);
  endtask

  task automatic test_clr();
    logic [15:0] rd;
    int irq0;
    apb_write(RCtrl, 16'h3);
    tick();
    drive_level(1'b1, 4);
    apb_write(RCtrl, 16'h7);
    m_high = 0; m_period = 0; m_valid = 1'b0; m_ovf = 1'b0;
    for (int a = 1; a < 4; a++) begin
      apb_read(4'(a), rd);
      n_checks++;
      if (rd !== 16'h0) $display("FAIL clr_reg[%0d]: got %h want 0000", a, rd);
      else n_pass++;
    end
    apb_read(RCtrl, rd);
    n_checks++;
    if (rd !== 16'h3) $display("FAIL clr_ctrl_readback: got %h want 0003", rd);
    else n_pass++;
    irq0 = irq_seen;
    drive_level(1'b1, 3);
    drive_level(1'b0, 4);
    drive_level(1'b1, 2);
    drive_level(1'b0, 3);
    apb_read(RStatus, rd);
    n_checks++;
    if (rd !== exp_status()) $display("FAIL clr_no_early_publish: got %h want %h", rd, exp_status());
    else n_pass++;
    drive_level(1'b1, 2);
    drive_level(1'b0, 6);
    m_high = 2; m_period = 5; m_valid = 1'b1;
    apb_read(RHigh, rd);
    n_checks++;
    if (rd !== 16'(m_high)) $display("FAIL clr_next_high: got %0d want %0d", rd, m_high);
    else n_pass++;
    apb_read(RPeriod, rd);
    n_checks++;
    if (rd !== 16'(m_period)) $display("FAIL clr_next_period: got %0d want %0d", rd, m_period);
    else n_pass++;
    n_checks++;
    if (irq_seen - irq0 !== 1) $display("FAIL clr_next_irq: got %0d want 1", irq_seen - irq0);
    else n_pass++;
    // clr committing on the same edge as a publish
    irq0 = irq_seen;
    pwm_in = 1'b1;
    tick();
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = RCtrl; pwdata = 16'h7;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    drive_level(1'b1, 1);
    drive_level(1'b0, 6);
    m_high = 0; m_period = 0; m_valid = 1'b0;
    for (int a = 1; a < 4; a++) begin
      apb_read(4'(a), rd);
      n_checks++;
      if (rd !== 16'h0) $display("FAIL clr_vs_publish_reg[%0d]: got %h want 0000", a, rd);
      else n_pass++;
    end
    n_checks++;
    if (irq_seen - irq0 !== 0) $display("FAIL clr_vs_publish_irq: got %0d want 0", irq_seen - irq0);
    else n_pass++;
    apb_write(RCtrl, 16'h0);
  endtask

  task automatic test_en_toggle();
    logic [15:0] rd;
    int irq0;
    apb_write(RCtrl, 16'h3);
    tick();
    run_train(6, 11, 1);
    m_high = 6; m_period = 11; m_valid = 1'b1;
    apb_read(RPeriod, rd);
    n_checks++;
    if (rd !== 16'(m_period)) $display("FAIL en_first_period: got %0d want %0d", rd, m_period);
    else n_pass++;
    // Input is low here, so the FSM is part-way through a low phase
    apb_write(RCtrl, 16'h2);
    irq0 = irq_seen;
    drive_level(1'b1, 2);
    drive_level(1'b0, 3);
    apb_write(RCtrl, 16'h3);
    tick();
    drive_level(1'b1, 5);
    drive_level(1'b0, 4);
    apb_read(RHigh, rd);
    n_checks++;
    if (rd !== 16'(m_high)) $display("FAIL en_kept_high: got %0d want %0d", rd, m_high);
    else n_pass++;
    apb_read(RPeriod, rd);
    n_checks++;
    if (rd !== 16'(m_period)) $display("FAIL en_kept_period: got %0d want %0d", rd, m_period);
    else n_pass++;
    apb_read(RStatus, rd);
    n_checks++;
    if (rd !== exp_status()) $display("FAIL en_kept_status: got %h want %h", rd, exp_status());
    else n_pass++;
    n_checks++;
    if (irq_seen - irq0 !== 0) $display("FAIL en_no_stale_irq: got %0d want 0", irq_seen - irq0);
    else n_pass++;
    drive_level(1'b1, 2);
    drive_level(1'b0, 6);
    m_high = 5; m_period = 9;
    apb_read(RHigh, rd);
    n_checks++;
    if (rd !== 16'(m_high)) $display("FAIL en_resume_high: got %0d want %0d", rd, m_high);
    else n_pass++;
    apb_read(RPeriod, rd);
    n_checks++;
    if (rd !== 16'(m_period)) $display("FAIL en_resume_period: got %0d want %0d", rd, m_period);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [15:0] rd;
    drive_level(1'b1, 4);
    #2;
    preset = 1'b1;
    #1;
    for (int a = 0; a < 4; a++) begin
      apb_read(4'(a), rd);
      n_checks++;
      if (rd !== 16'h0) $display("FAIL async_reset_reg[%0d]: got %h want 0000", a, rd);
      else n_pass++;
    end
    n_checks++;
    if (meas_irq !== 1'b0) $display("FAIL async_reset_irq: got %b want 0", meas_irq);
    else n_pass++;
    pwm_in = 1'b0;
    repeat (2) tick();
    preset = 1'b0;
    tick();
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pwm_in = 1'b0;
    test_reset();
    test_measure();
    test_w1c();
    test_ovf();
    test_clr();
    test_en_toggle();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
